// File: rtl/input_port_arbiter.sv
`timescale 1ns/1ps
// input_port_arbiter
//
// Round-robin arbiter that merges NUM_IN_PORTS single-entry request holding
// registers onto one registered valid/ready output stream. Each port is
// granted in turn, starting after the last granted port. Ports that keep
// waiting while the output is back-pressured raise a sticky starve flag.
//
// Ports:
//   clk          single clock
//   reset        synchronous, active-low reset
//   req_vld      per-port request valid
//   req_packet   per-port packets, port i at [PACKET_BITS*i +: PACKET_BITS]
//   req_rdy      per-port ready (holding register empty and not in reset)
//   out_packet   granted packet (registered)
//   out_vld      output valid
//   out_rdy      downstream ready
//   grant_idx    port index of the packet in out_packet
//   starve_flag  sticky per-port starvation indication
//
// Output slot FSM:
//   state   | meaning
//   S_EMPTY | out_vld=0, nothing presented downstream
//   S_FULL  | out_vld=1, out_packet/grant_idx hold a granted packet

module input_port_arbiter #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_IN_PORTS  = 7,
  parameter int NUM_PORT_BITS = 4,
  parameter int WAIT_BITS     = 8,
  parameter int STARVE_LIMIT  = 200
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_IN_PORTS-1:0]             req_vld,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0] req_packet,
  output logic [NUM_IN_PORTS-1:0]             req_rdy,
  output logic [PACKET_BITS-1:0]              out_packet,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic [NUM_PORT_BITS-1:0]            grant_idx,
  output logic [NUM_IN_PORTS-1:0]             starve_flag
);

  localparam int PW = NUM_PORT_BITS + 1;
  localparam logic [PW-1:0] ONE_P = PW'(1);
  localparam logic [PW-1:0] NUM_P = PW'(NUM_IN_PORTS);
  localparam logic [WAIT_BITS-1:0] LIMIT_W = WAIT_BITS'(STARVE_LIMIT);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  slot_state_e state_q, state_d;

  logic [NUM_IN_PORTS-1:0]  hold_vld_q, hold_vld_d;
  logic [PACKET_BITS-1:0]   hold_pkt_q [NUM_IN_PORTS];
  logic [NUM_PORT_BITS-1:0] last_grant_q, last_grant_d;
  logic [PACKET_BITS-1:0]   out_packet_q, out_packet_d;
  logic [NUM_PORT_BITS-1:0] grant_idx_q, grant_idx_d;
  logic [WAIT_BITS-1:0]     wait_q [NUM_IN_PORTS];
  logic [WAIT_BITS-1:0]     wait_d [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0]  starve_q, starve_d;

  logic                     slot_free;
  logic                     any_hold;
  logic                     grant_fire;
  logic [NUM_IN_PORTS-1:0]  grant_oh;
  logic [NUM_IN_PORTS-1:0]  capture;
  logic [NUM_PORT_BITS-1:0] win_idx;

  logic [NUM_IN_PORTS-1:0]  rot;
  logic [PW-1:0]            start;
  logic [PW-1:0]            first_j;
  logic [PW-1:0]            sum;

  assign req_rdy     = {NUM_IN_PORTS{reset}} & ~hold_vld_q;
  assign capture     = req_vld & req_rdy;
  assign any_hold    = |hold_vld_q;
  assign slot_free   = (state_q == S_EMPTY) || out_rdy;
  assign grant_fire  = slot_free && any_hold;

  assign out_vld     = (state_q == S_FULL);
  assign out_packet  = out_packet_q;
  assign grant_idx   = grant_idx_q;
  assign starve_flag = starve_q;

  // Rotate the hold vector so bit 0 is the port right after last_grant;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    start   = {1'b0, last_grant_q} + ONE_P;
    rot     = NUM_IN_PORTS'({hold_vld_q, hold_vld_q} >> start);
    first_j = '0;
    for (int j = NUM_IN_PORTS - 1; j >= 0; j--) begin
      if (rot[j]) first_j = PW'(j);
    end
    // start <= N and first_j <= N-1, so one conditional subtract wraps it.
    sum = start + first_j;
    if (sum >= NUM_P) sum = sum - NUM_P;
    win_idx = NUM_PORT_BITS'(sum);
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      grant_oh[i] = grant_fire && (win_idx == NUM_PORT_BITS'(i));
    end
  end

  // A held port is never ready, so capture and grant never hit the same port.
  assign hold_vld_d = (hold_vld_q & ~grant_oh) | capture;

  always_comb begin
    starve_d = starve_q;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      wait_d[i] = wait_q[i];
      if (!hold_vld_q[i] || grant_oh[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != {WAIT_BITS{1'b1}}) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
      if (wait_d[i] == LIMIT_W) starve_d[i] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    out_packet_d = out_packet_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_EMPTY: begin
        if (any_hold) state_d = S_FULL;
      end
      S_FULL: begin
        if (out_rdy && !any_hold) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
    if (grant_fire) begin
      out_packet_d = hold_pkt_q[win_idx];
      grant_idx_d  = win_idx;
      last_grant_d = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_EMPTY;
      hold_vld_q   <= '0;
      last_grant_q <= NUM_PORT_BITS'(NUM_IN_PORTS - 1);
      out_packet_q <= '0;
      grant_idx_q  <= '0;
      starve_q     <= '0;
      for (int i = 0; i < NUM_IN_PORTS; i++) wait_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      hold_vld_q   <= hold_vld_d;
      last_grant_q <= last_grant_d;
      out_packet_q <= out_packet_d;
      grant_idx_q  <= grant_idx_d;
      starve_q     <= starve_d;
      for (int i = 0; i < NUM_IN_PORTS; i++) wait_q[i] <= wait_d[i];
    end
  end

  // Packet storage is qualified by hold_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (capture[i]) hold_pkt_q[i] <= req_packet[PACKET_BITS*i +: PACKET_BITS];
    end
  end

endmodule

// File: tb/tb_input_port_arbiter.sv
`timescale 1ns/1ps
module tb_input_port_arbiter;
  localparam int PB    = 97;
  localparam int N     = 7;
  localparam int PBITS = 4;
  localparam int WB    = 8;
  localparam int LIM   = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_vld;
  logic [PB*N-1:0]   req_packet;
  logic [N-1:0]      req_rdy;
  logic [PB-1:0]     out_packet;
  logic              out_vld;
  logic              out_rdy;
  logic [PBITS-1:0]  grant_idx;
  logic [N-1:0]      starve_flag;

  always #5 clk = ~clk;

  input_port_arbiter #(
    .PACKET_BITS(PB), .NUM_IN_PORTS(N), .NUM_PORT_BITS(PBITS),
    .WAIT_BITS(WB), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_packet(req_packet),
    .req_rdy(req_rdy), .out_packet(out_packet), .out_vld(out_vld),
    .out_rdy(out_rdy), .grant_idx(grant_idx), .starve_flag(starve_flag)
  );

  typedef struct packed {
    logic [PBITS-1:0] idx;
    logic [PB-1:0]    pkt;
  } beat_t;

  beat_t sb_q[$];
  int    glog[$];
  int    n_cmp = 0;
  int    n_err = 0;

  int    rr_cnt[N];
  int    rr_n  = 0;
  bit    rr_on = 1'b0;

  // Reference model state: what is held per port, what sits in the output slot.
  bit             m_hold[N];
  logic [PB-1:0]  m_pkt[N];
  int             m_last;
  bit             m_ovld;
  logic [PB-1:0]  m_opkt;
  int             m_oidx;
  int             m_wait[N];
  logic [N-1:0]   m_starve;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [PB-1:0] rand_pkt();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[PB-1:0];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_hold[i] = 1'b0;
      m_wait[i] = 0;
    end
    m_last   = N - 1;
    m_ovld   = 1'b0;
    m_opkt   = '0;
    m_oidx   = 0;
    m_starve = '0;
    sb_q.delete();
  endfunction

  // One cycle: compare DUT against the model at the falling edge, advance the
  // model for the coming rising edge, then let the caller change inputs.
  task automatic step();
    bit    hold_old[N];
    bit    free;
    int    win;
    beat_t b;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk("req_rdy", req_rdy[i], reset && !m_hold[i]);
    chk("out_vld", out_vld, m_ovld);
    if (m_ovld) begin
      chk("grant_idx", grant_idx, m_oidx);
      chk("out_packet", out_packet, m_opkt);
    end
    chk("starve_flag", starve_flag, m_starve);

    if (!reset) begin
      model_reset();
    end else begin
      free = !m_ovld || out_rdy;
      win  = -1;
      if (free) begin
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (m_last + k) % N;
          if (win < 0 && m_hold[p]) win = p;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!m_hold[i] || i == win) m_wait[i] = 0;
        else if (m_wait[i] < (1 << WB) - 1) m_wait[i]++;
        if (m_wait[i] == LIM) m_starve[i] = 1'b1;
      end
      if (free) begin
        if (win >= 0) begin
          m_ovld = 1'b1;
          m_opkt = m_pkt[win];
          m_oidx = win;
          m_last = win;
          b.idx  = PBITS'(win);
          b.pkt  = m_pkt[win];
          sb_q.push_back(b);
        end else begin
          m_ovld = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) hold_old[i] = m_hold[i];
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && !hold_old[i]) begin
          m_hold[i] = 1'b1;
          m_pkt[i]  = req_packet[PB*i +: PB];
        end
      end
      if (win >= 0) m_hold[win] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_packets();
    for (int i = 0; i < N; i++) req_packet[PB*i +: PB] = rand_pkt();
  endtask

  // Scoreboard monitor: every accepted output beat must match the next
  // expected beat issued by the model.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && out_vld === 1'b1 && out_rdy === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_empty: got beat idx %0d, expected none", grant_idx);
        end else begin
          e = sb_q.pop_front();
          chk("sb_idx", grant_idx, e.idx);
          chk("sb_pkt", out_packet, e.pkt);
        end
        glog.push_back(int'(grant_idx));
        if (rr_on && rr_n < 14 && grant_idx < N) begin
          rr_cnt[grant_idx]++;
          rr_n++;
        end
      end
    end
  end

  initial begin
    reset      = 1'b0;
    req_vld    = '1;
    out_rdy    = 1'b1;
    req_packet = '0;
    rand_packets();
    for (int i = 0; i < N; i++) rr_cnt[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset held with every port requesting.
    repeat (3) step();

    // Release; all ports request continuously: round-robin and fairness.
    rr_on = 1'b1;
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rand_packets();
      step();
    end
    rr_on = 1'b0;
    chk("rr_grants", rr_n, 14);
    for (int i = 0; i < N; i++) chk("rr_fair", rr_cnt[i], 2);

    // Back-pressure for 5 cycles, then release.
    out_rdy = 1'b0;
    repeat (5) step();
    out_rdy = 1'b1;
    repeat (5) step();

    // Long stall so waiting ports (port 2 among them) reach the starve limit.
    out_rdy = 1'b0;
    repeat (15) step();
    out_rdy = 1'b1;
    repeat (10) step();
    chk("starve2_sticky", starve_flag[2], 1'b1);

    // Reset, then wrap: drain ports 0..5 so last grant is 5, then hold 1 and 6.
    req_vld = '0;
    reset   = 1'b0;
    repeat (2) step();
    glog.delete();
    reset   = 1'b1;
    rand_packets();
    req_vld = 7'b0111111;
    step();
    req_vld = '0;
    repeat (8) step();
    rand_packets();
    req_vld = 7'b1000010;
    step();
    req_vld = '0;
    repeat (5) step();
    chk("wrap_len", glog.size(), 8);
    if (glog.size() >= 2) begin
      chk("wrap_first", glog[glog.size()-2], 6);
      chk("wrap_second", glog[glog.size()-1], 1);
    end

    // Single request latency on port 3.
    req_packet[PB*3 +: PB] = 97'h1A5;
    req_vld = 7'b0001000;
    step();
    req_vld = '0;
    repeat (4) step();

    // Randomized traffic with bursts of back-pressure and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      rand_packets();
      req_vld = N'($urandom);
      out_rdy = (c % 200 < 40) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 299) != 0);
      step();
    end

    // Drain everything that is still in flight.
    reset   = 1'b1;
    req_vld = '0;
    out_rdy = 1'b1;
    repeat (12) step();
    chk("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_port_arbiter.md
# input_port_arbiter

Round-robin arbiter and scheduler that shares one leaf output stream among `NUM_IN_PORTS` packet requesters. Typical requesters are the per-port freespace-update/credit packets produced by the input port cluster. Each requester has a one-entry holding register. The block picks one held packet per cycle in round-robin order and presents it on a registered valid/ready output toward the leaf BFT interface. It also flags requesters that wait too long because of sustained back-pressure.

## Interface
Parameters:
- `PACKET_BITS`, 97, width of one NoC packet; passed through unmodified.
- `NUM_IN_PORTS`, 7, number of requesters (2..16).
- `NUM_PORT_BITS`, 4, width of the grant index; must satisfy 2^`NUM_PORT_BITS` >= `NUM_IN_PORTS`.
- `WAIT_BITS`, 8, width of each per-port wait counter.
- `STARVE_LIMIT`, 200, wait count at which the port's starve flag sets; must be < 2^`WAIT_BITS`.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-low reset.
- `req_vld`  in  `NUM_IN_PORTS`  per-port request valid.
- `req_packet`  in  `PACKET_BITS*NUM_IN_PORTS`  port i packet at `[PACKET_BITS*(i+1)-1 : PACKET_BITS*i]`.
- `req_rdy`  out  `NUM_IN_PORTS`  per-port ready; a transfer happens when vld&rdy.
- `out_packet`  out  `PACKET_BITS`  granted packet, registered.
- `out_vld`  out  1  output valid.
- `out_rdy`  in  1  downstream ready.
- `grant_idx`  out  `NUM_PORT_BITS`  index of the port whose packet is in `out_packet`; valid only while `out_vld`=1.
- `starve_flag`  out  `NUM_IN_PORTS`  sticky; bit i sets when port i's wait counter reaches `STARVE_LIMIT`.

## Operation
- **Holding registers.** Each port i has a holding register `hold_vld[i]`/`hold_pkt[i]`.
  - `req_rdy[i]` = `reset` & ~`hold_vld[i]`.
  - On `req_vld[i]`&`req_rdy[i]`, the packet is captured and `hold_vld[i]` is set.
- **Output slot.** The output slot is free when `out_vld`=0 or `out_rdy`=1.
- **Arbitration.** When the slot is free and any `hold_vld` is set:
  - The winner is the first set port searching from `last_grant+1` upward, wrapping modulo `NUM_IN_PORTS`.
  - On the next edge: `out_packet` takes the winner's packet, `grant_idx` takes the winner index, `out_vld` goes to 1, `hold_vld[winner]` clears, and `last_grant` takes the winner index.
- **Idle.** When the slot is free and no `hold_vld` is set, `out_vld` goes to 0 on the next edge. `out_packet` and `grant_idx` hold their values.
- **Stall.** When `out_vld`=1 and `out_rdy`=0, the output registers and `last_grant` hold. No holding register clears.
- **Same-port capture and grant.** Capture and grant on the same port in the same cycle is impossible, because `req_rdy`=0 while the port is held. A port re-readies the cycle after its grant.
- **Wait counters.** Port i's counter increments while `hold_vld[i]`=1 and port i is not the winner this cycle. It clears when port i is granted or has `hold_vld[i]`=0, and saturates at all-ones. `starve_flag[i]` sets when the counter equals `STARVE_LIMIT` and clears only on reset.
- **Stateless FSM.** The arbiter has no FSM beyond the output-slot states EMPTY (`out_vld`=0) and FULL (`out_vld`=1):
  - EMPTY -> FULL when any hold is valid.
  - FULL -> EMPTY when `out_rdy`=1 and no hold is valid.
  - FULL -> FULL on a stall, or on `out_rdy`=1 with any hold valid (back-to-back transfer).

## Timing
- **Reset.** While `reset`=0 at an edge:
  - `hold_vld`=0, `out_vld`=0, `out_packet`=0, `grant_idx`=0, `starve_flag`=0, and all wait counters = 0.
  - `last_grant` = `NUM_IN_PORTS`-1, so port 0 has first priority.
  - `req_rdy` is 0 combinationally while `reset`=0.
- **Reset mid-operation.** Held and output packets are discarded. The downstream must not rely on an `out_vld` beat that is interrupted by reset.
- **Latency.** A request accepted at edge t is in its holding register after t. It can appear with `out_vld`=1 after edge t+1, which is 2 cycles from `req_vld` to `out_vld` with no contention.
- **Throughput.** The output sustains 1 packet/cycle while `out_rdy`=1 and holds are available. A single port sustains 1 packet per 2 cycles.
- **Output stability.** `out_packet` and `grant_idx` are stable while `out_vld`=1 and `out_rdy`=0.
- **Fairness.** With all ports continuously requesting and `out_rdy`=1, every port is granted exactly once per `NUM_IN_PORTS` grants.

## Test plan
- **Reset.** Drive `reset`=0 for 3 cycles with all `req_vld`=1. Required: `req_rdy`=0, `out_vld`=0, `starve_flag`=0 throughout. After release, the first grant is `grant_idx`=0.
- **Single request latency.** Port 3 presents packet 0x1A5 for one cycle with `out_rdy`=1. Required: `out_vld`=1 with `out_packet`=0x1A5 and `grant_idx`=3 exactly 2 cycles later, for 1 cycle only.
- **Round-robin order.** With `NUM_IN_PORTS`=7, all ports request continuously and `out_rdy`=1. Required: `grant_idx` sequence is 0,1,2,3,4,5,6,0,... The first 14 grants contain each port exactly twice.
- **Back-pressure.** While `out_vld`=1, hold `out_rdy`=0 for 5 cycles. Required: `out_packet` and `grant_idx` unchanged and `req_rdy[i]`=0 for every held port. After release, the next port in order follows on the next cycle with no gap.
- **Starvation flag.** With `STARVE_LIMIT`=10, port 2 is held and `out_rdy` is held at 0 with the output slot full. Required: `starve_flag[2]` rises after the 10th waiting cycle and stays 1 after `out_rdy` returns to 1, until reset.
- **Wrap and sparse requests.** `last_grant`=5, and ports 1 and 6 are held. Required: grant port 6, then port 1.
